// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM behind a valid/ready handshake with programmable wait states.
// One response per accepted request; byte/half/word access with little-endian lanes.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic                 Clk,
  input logic                 Reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic          op_write;
  logic [1:0]    op_size;
  logic          op_uns;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic          op_misalign;
  logic          op_range;
  logic          op_err;
  logic [AW-1:0] op_idx;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   wr_word;
  logic          enter_resp;
  logic          mem_we;

  // In IDLE the live request is the operand so a zero-latency access can finish on accept.
  always_comb begin
    op_write = write_q;
    op_size  = size_q;
    op_uns   = uns_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == StIdle) begin
      op_write = bus.req_write;
      op_size  = bus.req_size;
      op_uns   = bus.req_unsigned;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end
  end

  always_comb begin
    op_misalign = 1'b0;
    unique case (op_size)
      2'b00:   op_misalign = |op_addr[1:0];
      2'b01:   op_misalign = op_addr[0];
      2'b10:   op_misalign = 1'b0;
      default: op_misalign = 1'b1;
    endcase
    op_range = ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
    op_err   = op_misalign | op_range;
    op_idx   = op_addr[AW+1:2];
    rd_word  = mem_q[op_idx];
    shifted  = rd_word >> {op_addr[1:0], 3'b000};
  end

  always_comb begin
    case (op_size)
      2'b01:   load_val = op_uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = op_uns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    wr_word = rd_word;
    case (op_size)
      2'b00:   wr_word = op_wdata;
      2'b01:   wr_word[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
      2'b10:   wr_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      default: wr_word = rd_word;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = (op_err || op_write) ? 32'd0 : load_val;
    end
    // A reset on the commit edge drops the store along with the request.
    mem_we = enter_resp & op_write & ~op_err & Reset;
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[op_idx] <= wr_word;
    end
  end

  // Outputs.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule
